// File: rtl/ifid_pipe_ctrl_if.sv
// Handshake bundle between the IF/ID sequencer and the fetch/decode/EX stages.
// slave is the sequencer side; master is the side that drives the requests.
interface ifid_pipe_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             imem_busy;
  logic             hazard_id;
  logic             mispred;
  logic [31:0]      mispred_pc;
  logic             stall_out;
  logic             flush_out;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [1:0]       state_out;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             hang;

  modport slave (
    input  imem_busy, hazard_id, mispred, mispred_pc,
    output stall_out, flush_out, redirect_valid, redirect_pc, state_out,
           stall_cnt, flush_cnt, hang
  );

  modport master (
    output imem_busy, hazard_id, mispred, mispred_pc,
    input  stall_out, flush_out, redirect_valid, redirect_pc, state_out,
           stall_cnt, flush_cnt, hang
  );
endinterface

// File: rtl/ifid_pipe_ctrl.sv
// IF/ID pipeline register sequencer: merges fetch-busy, load-use and mispredict
// into stall/flush, drives the PC redirect, perf counters and a stall watchdog.
module ifid_pipe_ctrl #(
  parameter int unsigned PENALTY_CYCLES = 2,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned WDOG_LIMIT     = 1024
) (
  input logic             i_clk,
  input logic             i_rst,
  ifid_pipe_ctrl_if.slave bus
);

  localparam int unsigned     RunW    = $clog2(WDOG_LIMIT + 1);
  localparam logic [3:0]      PenLoad = 4'(PENALTY_CYCLES);
  localparam logic [RunW-1:0] RunMax  = RunW'(WDOG_LIMIT);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2
  } state_e;

  state_e           r_state;
  logic [3:0]       r_pen;
  logic [RunW-1:0]  r_run;
  logic             r_rv;
  logic [31:0]      r_rpc;
  logic [CNT_W-1:0] r_scnt;
  logic [CNT_W-1:0] r_fcnt;
  logic             r_hang;

  logic             w_req;
  logic             w_flush;
  logic             w_stall;
  state_e           w_resume;
  logic [RunW-1:0]  w_run_nxt;

  assign w_req    = bus.imem_busy | bus.hazard_id;
  // Flush beats any stall request; both are held low for the whole reset.
  assign w_flush  = ~i_rst & (bus.mispred | (r_state == StFlush));
  assign w_stall  = ~i_rst & ~w_flush & w_req;
  assign w_resume = w_req ? StStall : StRun;

  assign w_run_nxt = !w_stall             ? '0    :
                     (r_run == RunMax)    ? r_run :
                     r_run + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StRun;
      r_pen   <= '0;
      r_run   <= '0;
      r_rv    <= 1'b0;
      r_rpc   <= '0;
      r_scnt  <= '0;
      r_fcnt  <= '0;
      r_hang  <= 1'b0;
    end else begin
      r_rv  <= bus.mispred;
      r_run <= w_run_nxt;
      if (w_run_nxt == RunMax) r_hang <= 1'b1;
      if (w_stall && (r_scnt != '1)) r_scnt <= r_scnt + 1'b1;

      if (bus.mispred) begin
        r_rpc <= bus.mispred_pc;
        if (r_fcnt != '1) r_fcnt <= r_fcnt + 1'b1;
        if (PENALTY_CYCLES == 0) begin
          r_state <= w_resume;
        end else begin
          r_state <= StFlush;
          r_pen   <= PenLoad;
        end
      end else begin
        case (r_state)
          StFlush: begin
            r_pen <= r_pen - 4'd1;
            if (r_pen <= 4'd1) r_state <= w_resume;
          end
          StRun, StStall: r_state <= w_resume;
          default:        r_state <= StRun;
        endcase
      end
    end
  end

  assign bus.flush_out      = w_flush;
  assign bus.stall_out      = w_stall;
  assign bus.redirect_valid = r_rv;
  assign bus.redirect_pc    = r_rpc;
  assign bus.state_out      = r_state;
  assign bus.stall_cnt      = r_scnt;
  assign bus.flush_cnt      = r_fcnt;
  assign bus.hang           = r_hang;

endmodule

// File: tb/tb_ifid_pipe_ctrl.sv
// Directed plus random checks of ifid_pipe_ctrl against a cycle-level reference
// model; two instances cover the default penalty and a zero-penalty small config.
module tb_ifid_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mp = 1'b0;
  logic        busy = 1'b0;
  logic        haz = 1'b0;
  logic [31:0] pc = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ifid_pipe_ctrl_if #(.CNT_W(32)) ifa ();
  ifid_pipe_ctrl_if #(.CNT_W(3))  ifb ();

  assign ifa.imem_busy  = busy;
  assign ifa.hazard_id  = haz;
  assign ifa.mispred    = mp;
  assign ifa.mispred_pc = pc;
  assign ifb.imem_busy  = busy;
  assign ifb.hazard_id  = haz;
  assign ifb.mispred    = mp;
  assign ifb.mispred_pc = pc;

  ifid_pipe_ctrl #(.PENALTY_CYCLES(2), .CNT_W(32), .WDOG_LIMIT(1024)) u_dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifa)
  );

  ifid_pipe_ctrl #(.PENALTY_CYCLES(0), .CNT_W(3), .WDOG_LIMIT(4)) u_dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifb)
  );

  // Reference model: flush cycles still owed, plus plain event counters.
  int          cfg_pen[2]  = '{2, 0};
  int          cfg_w[2]    = '{32, 3};
  int          cfg_lim[2]  = '{1024, 4};
  int          left[2];
  int          st[2];
  int          run[2];
  bit          rv[2];
  bit          hang[2];
  logic [31:0] rpc[2];
  longint unsigned scnt[2];
  longint unsigned fcnt[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      left[k] = 0; st[k] = 0; run[k] = 0; rv[k] = 0; hang[k] = 0;
      rpc[k] = '0; scnt[k] = 0; fcnt[k] = 0;
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      longint unsigned mx;
      bit fl, sl;
      mx = (64'd1 << cfg_w[k]) - 64'd1;
      fl = mp || (left[k] > 0);
      sl = !fl && (busy || haz);
      if (sl && scnt[k] < mx) scnt[k]++;
      run[k] = sl ? ((run[k] < cfg_lim[k]) ? run[k] + 1 : run[k]) : 0;
      if (run[k] >= cfg_lim[k]) hang[k] = 1;
      if (mp) begin
        left[k] = cfg_pen[k];
        rpc[k]  = pc;
        rv[k]   = 1;
        if (fcnt[k] < mx) fcnt[k]++;
      end else begin
        rv[k] = 0;
        if (left[k] > 0) left[k]--;
      end
      st[k] = (left[k] > 0) ? 2 : ((busy || haz) ? 1 : 0);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      logic [63:0] o_fl, o_sl, o_st, o_rv, o_rpc, o_sc, o_fc, o_hg;
      bit e_fl, e_sl;
      if (k == 0) begin
        o_fl = 64'(ifa.flush_out);      o_sl = 64'(ifa.stall_out);
        o_st = 64'(ifa.state_out);      o_rv = 64'(ifa.redirect_valid);
        o_rpc = 64'(ifa.redirect_pc);   o_sc = 64'(ifa.stall_cnt);
        o_fc = 64'(ifa.flush_cnt);      o_hg = 64'(ifa.hang);
      end else begin
        o_fl = 64'(ifb.flush_out);      o_sl = 64'(ifb.stall_out);
        o_st = 64'(ifb.state_out);      o_rv = 64'(ifb.redirect_valid);
        o_rpc = 64'(ifb.redirect_pc);   o_sc = 64'(ifb.stall_cnt);
        o_fc = 64'(ifb.flush_cnt);      o_hg = 64'(ifb.hang);
      end
      e_fl = !rst && (mp || (left[k] > 0));
      e_sl = !rst && !e_fl && (busy || haz);
      chk($sformatf("%s%0d.flush", tag, k), o_fl, 64'(e_fl));
      chk($sformatf("%s%0d.stall", tag, k), o_sl, 64'(e_sl));
      chk($sformatf("%s%0d.state", tag, k), o_st, 64'(st[k]));
      chk($sformatf("%s%0d.rv", tag, k), o_rv, 64'(rv[k]));
      chk($sformatf("%s%0d.rpc", tag, k), o_rpc, 64'(rpc[k]));
      chk($sformatf("%s%0d.scnt", tag, k), o_sc, scnt[k]);
      chk($sformatf("%s%0d.fcnt", tag, k), o_fc, fcnt[k]);
      chk($sformatf("%s%0d.hang", tag, k), o_hg, 64'(hang[k]));
    end
  endtask

  task automatic step(input logic m, input logic b, input logic h, input logic [31:0] p);
    @(negedge clk);
    mp = m; busy = b; haz = h; pc = p;
    #1;
    check_all("stp");
    model_update();
  endtask

  // Reset asserted asynchronously mid-cycle, optionally with requests still high.
  task automatic do_reset(input logic hold);
    @(negedge clk);
    rst = 1'b1; mp = hold; busy = hold; haz = 1'b0;
    #1;
    model_reset();
    check_all("rst");
    #2;
    rst = 1'b0; mp = 1'b0; busy = 1'b0; haz = 1'b0; pc = '0;
    #1;
    check_all("rel");
    model_update();
  endtask

  initial begin
    do_reset(1'b0);

    // Reset landing mid-flush with two penalty cycles still owed
    step(1'b1, 1'b0, 1'b0, 32'h0040_0100);
    do_reset(1'b1);
    chk("t1.state", 64'(ifa.state_out), 64'd0);
    chk("t1.flush", 64'(ifa.flush_out), 64'd0);

    // Load-use hazard for three cycles
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("t2.scnt", ifa.stall_cnt, 64'd3);
    chk("t2.state", 64'(ifa.state_out), 64'd1);

    // Single mispredict
    do_reset(1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0040_0100);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("t3.rv", 64'(ifa.redirect_valid), 64'd1);
    chk("t3.rpc", 64'(ifa.redirect_pc), 64'h0040_0100);
    chk("t3.fcnt", ifa.flush_cnt, 64'd1);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);

    // Mispredict while fetch is busy
    do_reset(1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0040_0180);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("t4.stall", 64'(ifa.stall_out), 64'd1);
    chk("t4.state", 64'(ifa.state_out), 64'd1);

    // Back-to-back mispredicts
    do_reset(1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0040_0100);
    step(1'b1, 1'b0, 1'b0, 32'h0040_0200);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("t5.flush", 64'(ifa.flush_out), 64'd1);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("t5.rpc", 64'(ifa.redirect_pc), 64'h0040_0200);
    chk("t5.fcnt", ifa.flush_cnt, 64'd2);

    // Long stall: watchdog and counter saturation on the small instance
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("t6.hang", 64'(ifb.hang), 64'd1);
    chk("t6.scnt", 64'(ifb.stall_cnt), 64'd7);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(63) == 0) begin
        do_reset(1'($urandom_range(1)));
      end else begin
        step(1'($urandom_range(7) == 0), 1'($urandom_range(2) == 0),
             1'($urandom_range(3) == 0), $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
